// File: rtl/seq_definitions.sv
// seq_definitions: shared payload width and UART transmitter state encodings.
package seq_definitions;

    localparam int seq_dp_width = 8;

    typedef enum logic [2:0] {
        seq_utx_idle,
        seq_utx_start,
        seq_utx_data,
        seq_utx_parity,
        seq_utx_stop
    } seq_utx_state_t;

endpackage

// File: rtl/seq_baud_gen.sv
// seq_baud_gen: bit-period counter 0..CLK_DIV-1 with terminal-count tick.
module seq_baud_gen #(
    parameter int CLK_DIV = 868
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    output logic o_tick
);

    logic [15:0] cnt_q;

    assign o_tick = cnt_q == 16'(CLK_DIV - 1);

    always_ff @(posedge clk or posedge rst)
        if (rst) cnt_q <= '0;
        else     cnt_q <= (i_clear || o_tick) ? '0 : cnt_q + 16'd1;

endmodule

// File: rtl/seq_uart_tx.sv
// seq_uart_tx: UART frame transmitter (start, LSB-first data, stop).
// Define SEQ_UART_TX_PARITY_EN to add an even-parity bit before the stop bit.
import seq_definitions::*;

module seq_uart_tx #(
    parameter int CLK_DIV    = 868,
    parameter int DATA_WIDTH = seq_dp_width
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_valid,
    output logic                  o_busy,
    output logic                  o_tx
);

    localparam int BW = $clog2(DATA_WIDTH + 1);

    seq_utx_state_t        state_q;
    logic [DATA_WIDTH-1:0] shift_q;
    logic [BW-1:0]         bit_q;
    logic                  tx_q;
    logic                  busy_q;
    logic                  tick;
`ifdef SEQ_UART_TX_PARITY_EN
    logic                  par_q;
`endif

    // Counter is held at zero while idle, so acceptance starts a fresh bit period.
    seq_baud_gen #(.CLK_DIV(CLK_DIV)) u_baud (
        .clk     (clk),
        .rst     (rst),
        .i_clear (state_q == seq_utx_idle),
        .o_tick  (tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= seq_utx_idle;
            shift_q <= '0;
            bit_q   <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
`ifdef SEQ_UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                seq_utx_idle: if (i_valid) begin
                    state_q <= seq_utx_start;
                    shift_q <= i_data;
                    bit_q   <= '0;
                    tx_q    <= 1'b0;
                    busy_q  <= 1'b1;
`ifdef SEQ_UART_TX_PARITY_EN
                    par_q   <= ^i_data;
`endif
                end
                seq_utx_start: if (tick) begin
                    state_q <= seq_utx_data;
                    tx_q    <= shift_q[0];
                    shift_q <= shift_q >> 1;
                end
                seq_utx_data: if (tick) begin
                    if (bit_q == BW'(DATA_WIDTH - 1)) begin
`ifdef SEQ_UART_TX_PARITY_EN
                        state_q <= seq_utx_parity;
                        tx_q    <= par_q;
`else
                        state_q <= seq_utx_stop;
                        tx_q    <= 1'b1;
`endif
                    end else begin
                        bit_q   <= bit_q + BW'(1);
                        tx_q    <= shift_q[0];
                        shift_q <= shift_q >> 1;
                    end
                end
                seq_utx_parity: if (tick) begin
                    state_q <= seq_utx_stop;
                    tx_q    <= 1'b1;
                end
                seq_utx_stop: if (tick) begin
                    state_q <= seq_utx_idle;
                    busy_q  <= 1'b0;
                end
                default: state_q <= seq_utx_idle;
            endcase
        end
    end

    assign o_tx   = tx_q;
    assign o_busy = busy_q;

endmodule

// File: tb/tb_seq_uart_tx.sv
// tb_seq_uart_tx: scoreboard bench; three DUTs at CLK_DIV 4, 1 and 2.
module tb_seq_uart_tx;

    typedef struct {
        logic [15:0] bits;
        int          n;
    } frame_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] data  [3];
    logic       valid [3];
    logic       tx    [3];
    logic       busy  [3];
    frame_t     q     [3][$];
    int         gap   [3];
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Expected line levels, one entry per bit period.
    function automatic frame_t mk(input logic [7:0] d);
        frame_t f;
        f.bits = '0;
        f.n = 0;
        f.bits[f.n] = 1'b0; f.n++;
        for (int k = 0; k < 8; k++) begin
            f.bits[f.n] = 1'((d >> k) & 8'd1);
            f.n++;
        end
`ifdef SEQ_UART_TX_PARITY_EN
        f.bits[f.n] = 1'($countones(d) % 2); f.n++;
`endif
        f.bits[f.n] = 1'b1; f.n++;
        return f;
    endfunction

    for (genvar g = 0; g < 3; g++) begin : inst
        localparam int D = (g == 0) ? 4 : ((g == 1) ? 1 : 2);
        seq_uart_tx #(.CLK_DIV(D), .DATA_WIDTH(8)) dut (
            .clk     (clk),
            .rst     (rst),
            .i_data  (data[g]),
            .i_valid (valid[g]),
            .o_busy  (busy[g]),
            .o_tx    (tx[g])
        );

        initial begin
            int idle;
            int t;
            frame_t f;
            bit ok;
            bit ab;
            idle = 0;
            forever begin
                @(negedge clk);
                if (rst) begin idle = 0; continue; end
                if (busy[g] !== 1'b1) begin idle++; continue; end
                gap[g] = idle;
                idle = 0;
                if (q[g].size() == 0) begin
                    chk($sformatf("unexpected_frame_dut%0d", g), 1, 0);
                    t = 0;
                    while (busy[g] === 1'b1 && !rst && t < 1000) begin @(negedge clk); t++; end
                    continue;
                end
                f = q[g].pop_front();
                ab = 0;
                for (int k = 0; k < f.n && !ab; k++) begin
                    ok = 1;
                    for (int c = 0; c < D; c++) begin
                        if (k != 0 || c != 0) @(negedge clk);
                        if (rst) begin ab = 1; break; end
                        if (tx[g] !== f.bits[k] || busy[g] !== 1'b1) ok = 0;
                    end
                    if (!ab) chk($sformatf("dut%0d_bit%0d_exp%0b", g, k, f.bits[k]), 32'(ok), 1);
                end
                if (!ab) begin
                    @(negedge clk);
                    if (!rst) begin
                        chk($sformatf("dut%0d_frame_end_busy_tx", g), {busy[g], tx[g]}, 2'b01);
                        idle = 1;
                    end
                end
            end
        end
    end

    task automatic send(input int g, input logic [7:0] d, input bit hold);
        int t = 0;
        @(negedge clk);
        data[g]  = d;
        valid[g] = 1'b1;
        while (busy[g] === 1'b1 && t < 2000) begin @(negedge clk); t++; end
        if (t >= 2000) chk("send_timeout", 1, 0);
        q[g].push_back(mk(d));
        @(negedge clk);
        if (!hold) valid[g] = 1'b0;
    endtask

    task automatic wait_idle(input int g);
        int t = 0;
        while ((q[g].size() != 0 || busy[g] === 1'b1) && t < 5000) begin @(negedge clk); t++; end
        if (t >= 5000) chk("idle_timeout", 1, 0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        logic [7:0] d;
        int g;
        for (int i = 0; i < 3; i++) begin
            valid[i] = 1'b0;
            data[i]  = '0;
            gap[i]   = 0;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) chk($sformatf("reset_busy_tx_dut%0d", i), {busy[i], tx[i]}, 2'b01);

        // First acceptance on the first edge after reset release: 0x55.
        rst = 1'b0;
        data[0]  = 8'h55;
        valid[0] = 1'b1;
        q[0].push_back(mk(8'h55));
        @(posedge clk);
        #1 chk("first_accept_busy", busy[0], 1);
        @(negedge clk);
        valid[0] = 1'b0;
        wait_idle(0);

        // Back-to-back with i_valid held high.
        send(0, 8'hA3, 1);
        send(0, 8'h3C, 0);
        wait_idle(0);
        chk("back_to_back_gap", gap[0], 1);

        // Request during a frame is dropped.
        send(0, 8'h00, 0);
        repeat (10) @(negedge clk);
        data[0]  = 8'hFF;
        valid[0] = 1'b1;
        @(negedge clk);
        valid[0] = 1'b0;
        wait_idle(0);
        repeat (60) @(negedge clk);

        // Asynchronous reset mid-frame, then a clean frame.
        send(0, 8'h5A, 0);
        repeat (16) @(negedge clk);
        #1 rst = 1'b1;
        #1 chk("async_reset_busy_tx", {busy[0], tx[0]}, 2'b01);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        send(0, 8'h5A, 0);
        wait_idle(0);

        // Parity cases at CLK_DIV=2 and minimum divider.
        send(2, 8'h07, 0);
        wait_idle(2);
        send(2, 8'h03, 0);
        wait_idle(2);
        send(1, 8'h81, 0);
        wait_idle(1);

        for (int i = 0; i < 24; i++) begin
            g = int'($urandom_range(0, 2));
            d = 8'($urandom);
            send(g, d, 0);
            if ($urandom_range(0, 1) == 1 && busy[g] === 1'b1) begin
                data[g]  = 8'($urandom);
                valid[g] = 1'b1;
                @(negedge clk);
                valid[g] = 1'b0;
            end
            repeat ($urandom_range(0, 5)) @(negedge clk);
        end
        for (int i = 0; i < 3; i++) begin
            wait_idle(i);
            repeat (50) @(negedge clk);
            chk($sformatf("queue_empty_dut%0d", i), q[i].size(), 0);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
